// File: rtl/pwm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_if: SPI control-register bundle in, PWM output bank out.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pwm_if;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        period_start;

   modport master (
      output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
      output pwm_duty_cycle,
      input  out, period_start
   );

   modport slave (
      input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
      input  pwm_duty_cycle,
      output out, period_start
   );
endinterface
`default_nettype wire

// File: rtl/pwm_peripheral.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_peripheral: prescaled 8-bit PWM driving 16 gated/static/PWM outputs. |
// | Option: define PWM_SHADOW_EN to latch duty at each period wrap.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pwm_peripheral #(
   parameter int PRESCALE = 13,
   parameter int CNT_MAX  = 254
) (
   input  logic clk,
   input  logic rst_n,
   pwm_if.slave bus
);
   localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [7:0]      CNT_LAST = 8'(CNT_MAX);

   logic [PS_W-1:0] prescale_q, prescale_d;
   logic [7:0]      pwm_cnt_q, pwm_cnt_d;
   logic [15:0]     out_q, out_d;
   logic            period_start_q, period_start_d;

   logic            w_tick;
   logic            w_wrap;
   logic            w_level;
   logic [7:0]      w_duty;
   logic [15:0]     w_en_out;
   logic [15:0]     w_en_pwm;

   assign w_tick   = (prescale_q == PS_LAST);
   assign w_wrap   = w_tick && (pwm_cnt_q == CNT_LAST);
   assign w_en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
   assign w_en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

`ifdef PWM_SHADOW_EN
   // Duty only changes at a period boundary so a mid-period write cannot split a pulse.
   logic [7:0] duty_q, duty_d;

   always_comb begin
      duty_d = w_wrap ? bus.pwm_duty_cycle : duty_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q <= 8'h00;
      end else begin
         duty_q <= duty_d;
      end
   end

   assign w_duty = duty_q;
`else
   assign w_duty = bus.pwm_duty_cycle;
`endif

   assign w_level = (w_duty == 8'hFF) || ((w_duty != 8'h00) && (pwm_cnt_q < w_duty));

   always_comb begin
      prescale_d     = w_tick ? '0 : prescale_q + 1'b1;
      pwm_cnt_d      = pwm_cnt_q;
      if (w_tick) begin
         pwm_cnt_d = w_wrap ? 8'h00 : pwm_cnt_q + 8'h01;
      end
      period_start_d = w_wrap;
      // Disabled bits are 0, static bits are 1, PWM bits follow the shared level.
      out_d          = w_en_out & (~w_en_pwm | {16{w_level}});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_q     <= '0;
         pwm_cnt_q      <= 8'h00;
         out_q          <= 16'h0000;
         period_start_q <= 1'b0;
      end else begin
         prescale_q     <= prescale_d;
         pwm_cnt_q      <= pwm_cnt_d;
         out_q          <= out_d;
         period_start_q <= period_start_d;
      end
   end

   assign bus.out          = out_q;
   assign bus.period_start = period_start_q;
endmodule
`default_nettype wire
